// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: gathers WIDTH strobed bits into a word and
// presents it through a one-word valid/ready holding register with sticky overrun.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in,
    input  logic             i_in_valid,
    input  logic             i_frame,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_busy,
    output logic             o_overrun,
    input  logic             i_ovr_clr
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_first;
    logic               w_complete;
    logic               w_accept;
    logic [WIDTH-1:0]   r_dout;
    logic [WIDTH-1:0]   w_dout_nxt;
    logic               r_dout_valid;
    logic               w_dout_valid_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;

    // Bit ordering: the shifted-in bit and the first bit of a framed word
    always_comb begin
        if (MSB_FIRST) begin
            w_shifted = {r_shift[WIDTH-2:0], i_in};
            w_first   = {{(WIDTH-1){1'b0}}, i_in};
        end else begin
            w_shifted = {i_in, r_shift[WIDTH-1:1]};
            w_first   = {i_in, {(WIDTH-1){1'b0}}};
        end
    end

    // Next-state: bit counter, shift register and holding register
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_complete       = 1'b0;
        w_accept         = r_dout_valid & i_dout_ready;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = r_dout_valid;
        w_overrun_nxt    = r_overrun;

        if (i_in_valid) begin
            if (i_frame) begin
                // A frame marker always restarts, even on what would be the last bit
                w_shift_nxt = w_first;
                w_cnt_nxt   = CW'(1);
            end else begin
                w_shift_nxt = w_shifted;
                if (r_cnt == LAST_CNT) begin
                    w_complete = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
        end

        w_state_nxt = (w_cnt_nxt == '0) ? S_IDLE : S_SHIFT;

        if (i_ovr_clr) begin
            w_overrun_nxt = 1'b0;
        end

        // A drop in the same cycle as a clear leaves overrun set
        if (w_complete) begin
            if (!r_dout_valid || w_accept) begin
                w_dout_nxt       = w_shifted;
                w_dout_valid_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end else if (w_accept) begin
            w_dout_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = (r_state == S_SHIFT);
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share stimulus;
// a queue scoreboard checks every accepted word, directed sequences cover the corners.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_in;
    logic       in_valid;
    logic       frame;
    logic       dout_ready;
    logic       ovr_clr;

    logic [3:0] dout_m;
    logic       valid_m;
    logic       busy_m;
    logic       ovr_m;
    logic [3:0] dout_l;
    logic       valid_l;
    logic       busy_l;
    logic       ovr_l;

    int total = 0;
    int bad   = 0;

    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    typedef struct {
        logic [7:0]  in_b;
        logic [7:0]  fr_b;
        logic [7:0]  v_b;
        int          n;
        logic [3:0]  exp_m;
        logic [3:0]  exp_l;
    } vec_t;

    vec_t vecs[4];

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst(rst), .i_in(s_in), .i_in_valid(in_valid),
        .i_frame(frame), .o_dout(dout_m), .o_dout_valid(valid_m),
        .i_dout_ready(dout_ready), .o_busy(busy_m), .o_overrun(ovr_m),
        .i_ovr_clr(ovr_clr)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst(rst), .i_in(s_in), .i_in_valid(in_valid),
        .i_frame(frame), .o_dout(dout_l), .o_dout_valid(valid_l),
        .i_dout_ready(dout_ready), .o_busy(busy_l), .o_overrun(ovr_l),
        .i_ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic v, input logic f);
        s_in     = b;
        in_valid = v;
        frame    = f;
        tick();
        in_valid = 1'b0;
        frame    = 1'b0;
    endtask

    // Scoreboard: every handshake pops one expected word per instance
    always @(negedge clk) begin
        if (!rst && valid_m && dout_ready) begin
            if (q_m.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_msb_unexpected: got %0h expected none", dout_m);
            end else begin
                check("sb_msb_word", 32'(dout_m), 32'(q_m.pop_front()));
            end
        end
        if (!rst && valid_l && dout_ready) begin
            if (q_l.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_lsb_unexpected: got %0h expected none", dout_l);
            end else begin
                check("sb_lsb_word", 32'(dout_l), 32'(q_l.pop_front()));
            end
        end
    end

    task automatic run_row(input vec_t r);
        q_m.push_back(r.exp_m);
        q_l.push_back(r.exp_l);
        for (int i = 0; i < r.n; i++) begin
            drive(r.in_b[7-i], r.v_b[7-i], r.fr_b[7-i]);
        end
        check("row_valid_m_pulse", 32'(valid_m), 32'd1);
        check("row_valid_l_pulse", 32'(valid_l), 32'd1);
        tick();
        check("row_valid_m_drop", 32'(valid_m), 32'd0);
        check("row_busy_m", 32'(busy_m), 32'd0);
        check("row_sb_empty", 32'(q_m.size() + q_l.size()), 32'd0);
        tick();
    endtask

    initial begin
        // Slot 0 is the leftmost bit of each 8-bit field
        vecs[0] = '{in_b: 8'b1011_0000, fr_b: 8'b1000_0000, v_b: 8'b1111_0000,
                    n: 4, exp_m: 4'b1011, exp_l: 4'b1101};
        vecs[1] = '{in_b: 8'b1101_1000, fr_b: 8'b0010_0000, v_b: 8'b1111_1100,
                    n: 6, exp_m: 4'b0110, exp_l: 4'b0110};
        vecs[2] = '{in_b: 8'b1010_0010, fr_b: 8'b1001_0000, v_b: 8'b1010_0110,
                    n: 7, exp_m: 4'b1101, exp_l: 4'b1011};
        vecs[3] = '{in_b: 8'b1110_0100, fr_b: 8'b1001_0000, v_b: 8'b1111_1110,
                    n: 7, exp_m: 4'b0010, exp_l: 4'b0100};

        rst = 1'b1; s_in = 1'b0; in_valid = 1'b0; frame = 1'b0;
        dout_ready = 1'b1; ovr_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_dout_m", 32'(dout_m), 32'd0);
        check("rst_valid_m", 32'(valid_m), 32'd0);
        check("rst_busy_m", 32'(busy_m), 32'd0);
        check("rst_ovr_m", 32'(ovr_m), 32'd0);
        check("rst_valid_l", 32'(valid_l), 32'd0);
        tick();

        for (int k = 0; k < 4; k++) run_row(vecs[k]);

        // Continuous strobe, two words back to back
        q_m.push_back(4'hC); q_m.push_back(4'h3);
        q_l.push_back(4'h3); q_l.push_back(4'hC);
        begin
            logic [7:0] seq;
            seq = 8'b1100_0011;
            for (int i = 0; i < 8; i++) begin
                s_in = seq[7-i]; in_valid = 1'b1; frame = (i == 0);
                tick();
                if (i == 3) check("b2b_valid_first", 32'(valid_m), 32'd1);
            end
            in_valid = 1'b0; frame = 1'b0;
        end
        check("b2b_valid_second", 32'(valid_m), 32'd1);
        check("b2b_dout_m", 32'(dout_m), 32'h3);
        tick(); tick();
        check("b2b_sb_empty", 32'(q_m.size() + q_l.size()), 32'd0);

        // Overrun: consumer stalled, second word dropped
        dout_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1); drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0); drive(1'b0, 1'b1, 1'b0);
        check("ovr_first_m", 32'(dout_m), 32'hA);
        check("ovr_first_l", 32'(dout_l), 32'h5);
        check("ovr_none_yet", 32'(ovr_m), 32'd0);
        drive(1'b0, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
        check("ovr_hold_m", 32'(dout_m), 32'hA);
        check("ovr_hold_l", 32'(dout_l), 32'h5);
        check("ovr_valid_m", 32'(valid_m), 32'd1);
        check("ovr_set_m", 32'(ovr_m), 32'd1);
        check("ovr_set_l", 32'(ovr_l), 32'd1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("ovr_clr_m", 32'(ovr_m), 32'd0);
        check("ovr_clr_l", 32'(ovr_l), 32'd0);
        check("ovr_clr_valid", 32'(valid_m), 32'd1);
        drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
        s_in = 1'b1; in_valid = 1'b1; ovr_clr = 1'b1;
        tick();
        in_valid = 1'b0; ovr_clr = 1'b0;
        check("ovr_set_wins", 32'(ovr_m), 32'd1);
        check("ovr_set_wins_dout", 32'(dout_m), 32'hA);
        q_m.push_back(4'hA); q_l.push_back(4'h5);
        dout_ready = 1'b1;
        tick(); tick();
        check("drain_valid", 32'(valid_m), 32'd0);
        check("drain_sb_empty", 32'(q_m.size() + q_l.size()), 32'd0);

        // Reset mid-word discards the partial bits
        drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
        check("mid_busy_m", 32'(busy_m), 32'd1);
        rst = 1'b1; s_in = 1'b1; in_valid = 1'b1; frame = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst2_busy_m", 32'(busy_m), 32'd0);
        check("rst2_busy_l", 32'(busy_l), 32'd0);
        check("rst2_ovr_m", 32'(ovr_m), 32'd0);
        check("rst2_dout_m", 32'(dout_m), 32'd0);
        q_m.push_back(4'h9); q_l.push_back(4'h9);
        drive(1'b1, 1'b1, 1'b0); drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
        check("rst2_word_m", 32'(dout_m), 32'h9);
        tick(); tick();
        check("rst2_ovr_after", 32'(ovr_m), 32'd0);
        check("final_sb_empty", 32'(q_m.size() + q_l.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
